add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter.sv | 166 ++++++++++++++++
 tb/tb_add_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_arbiter.sv
// add_arbiter: two requesters share one signed WIDTH-bit ripple-carry adder.
// A round-robin arbiter grants one pending operation at a time. The grant
// captures the operands and walks them through LOAD -> EXEC -> RESP. The
// result is then held until the consumer accepts it.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   r0_valid/r0_ready             requester 0 handshake
//   r0_inA, r0_inB, r0_Cin        requester 0 operands and carry-in
//   r1_*                          same for requester 1
//   rsp_valid/rsp_ready           response handshake
//   rsp_id                        requester that issued the held result
//   rsp_add, rsp_Co, rsp_ovf      sum, carry-out of MSB, signed overflow
//   op_count                      completed responses (wraps at 16 bits)
//   dbg_state                     current FSM state (IDLE=0 LOAD=1 EXEC=2 RESP=3)
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both high. A valid that drops before it is granted has
// no effect. Readys never depend on the other side's ready.

module add_arbiter_rca #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             co
);
  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign co = carry[WIDTH];
endmodule

module add_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_inA,
  input  logic [WIDTH-1:0] r0_inB,
  input  logic             r0_Cin,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_inA,
  input  logic [WIDTH-1:0] r1_inB,
  input  logic             r1_Cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_add,
  output logic             rsp_Co,
  output logic             rsp_ovf,
  output logic [15:0]      op_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_n;

  logic             last_grant;
  logic             gnt_id;
  logic             take;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             op_id;

  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  // On a tie the requester that was not served last wins. With a single
  // valid that requester wins. gnt_id only matters when some valid is high.
  assign gnt_id = (r0_valid & r1_valid) ? ~last_grant : r1_valid;

  always_comb begin
    state_n  = state;
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    take     = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && (r0_valid || r1_valid)) begin
          r0_ready = ~gnt_id;
          r1_ready = gnt_id;
          take     = 1'b1;
          state_n  = LOAD;
        end
      end
      LOAD: state_n = EXEC;
      EXEC: state_n = RESP;
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  add_arbiter_rca #(.WIDTH(WIDTH)) u_rca (
    .a   (op_a),
    .b   (op_b),
    .cin (op_cin),
    .sum (sum),
    .co  (co)
  );

  // Signed overflow: operands share a sign and the result sign differs.
  assign ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) & (sum[WIDTH-1] != op_a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_count   <= 16'd0;
      rsp_valid  <= 1'b0;
      rsp_add    <= '0;
      rsp_Co     <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_id     <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_cin     <= 1'b0;
      op_id      <= 1'b0;
    end else begin
      state <= state_n;
      if (take) begin
        op_a       <= gnt_id ? r1_inA : r0_inA;
        op_b       <= gnt_id ? r1_inB : r0_inB;
        op_cin     <= gnt_id ? r1_Cin : r0_Cin;
        op_id      <= gnt_id;
        last_grant <= gnt_id;
      end
      if (state == EXEC) begin
        rsp_add   <= sum;
        rsp_Co    <= co;
        rsp_ovf   <= ovf;
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 16'd1;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_add_arbiter.sv
module tb_add_arbiter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_valid, r1_valid;
  logic          r0_ready, r1_ready;
  logic [W-1:0]  r0_inA, r0_inB, r1_inA, r1_inB;
  logic          r0_Cin, r1_Cin;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0]  rsp_add;
  logic          rsp_Co, rsp_ovf;
  logic [15:0]   op_count;
  logic [1:0]    dbg_state;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [15:0]   exp_count;
  logic [34:0]   exp_q[$];   // {id, co, ovf, add}

  typedef struct packed {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] add;
    logic         co;
    logic         ovf;
  } vec_t;

  vec_t vecs[6];

  add_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_inA(r0_inA), .r0_inB(r0_inB), .r0_Cin(r0_Cin),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_inA(r1_inA), .r1_inB(r1_inB), .r1_Cin(r1_Cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_add(rsp_add), .rsp_Co(rsp_Co), .rsp_ovf(rsp_ovf),
    .op_count(op_count), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_r0_ready", r0_ready, 1'b0);
    check_eq("rst_r1_ready", r1_ready, 1'b0);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    rst = 1'b0;
    exp_count = 16'd0;
  endtask

  // Presents one operation and returns #1 after the handshake edge.
  task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int t;
    @(negedge clk);
    if (id) begin
      r1_valid = 1'b1; r1_inA = a; r1_inB = b; r1_Cin = cin;
    end else begin
      r0_valid = 1'b1; r0_inA = a; r0_inB = b; r0_Cin = cin;
    end
    #1;
    t = 0;
    while (!(id ? r1_ready : r0_ready) && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    check_eq("grant_wait", (t < 20), 1'b1);
    check_eq("other_ready", (id ? r0_ready : r1_ready), 1'b0);
    @(posedge clk);
    #1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
  endtask

  // Scoreboard side: collects the next response, holding rsp_ready low for bp cycles.
  task automatic expect_rsp(input int bp);
    logic [34:0] exp;
    exp = exp_q.pop_front();
    rsp_ready = (bp == 0);
    @(posedge clk); #1;
    check_eq("lat_exec_no_valid", rsp_valid, 1'b0);
    @(posedge clk); #1;
    check_eq("lat_n3_valid", rsp_valid, 1'b1);
    check_eq("rsp_id", rsp_id, exp[34]);
    check_eq("rsp_Co", rsp_Co, exp[33]);
    check_eq("rsp_ovf", rsp_ovf, exp[32]);
    check_eq("rsp_add", rsp_add, exp[31:0]);
    if (bp > 0) begin
      r0_valid = 1'b1;
      r1_valid = 1'b1;
      for (int k = 0; k < bp; k++) begin
        @(posedge clk); #1;
        check_eq("bp_valid", rsp_valid, 1'b1);
        check_eq("bp_stable", {rsp_id, rsp_Co, rsp_ovf, rsp_add}, exp);
        check_eq("bp_count", op_count, exp_count);
        check_eq("bp_readys", {r0_ready, r1_ready}, 2'b00);
      end
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    exp_count = exp_count + 16'd1;
    check_eq("accept_valid_low", rsp_valid, 1'b0);
    check_eq("op_count", op_count, exp_count);
    check_eq("back_idle", dbg_state, 2'd0);
  endtask

  initial begin
    rst = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_inA = '0; r0_inB = '0; r0_Cin = 1'b0;
    r1_inA = '0; r1_inB = '0; r1_Cin = 1'b0;
    rsp_ready = 1'b0;
    exp_count = 16'd0;

    //         id    a              b              cin   add            co    ovf
    vecs[0] = {1'b0, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'h0000_000D, 1'b0, 1'b0};
    vecs[1] = {1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = {1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[3] = {1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[4] = {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[5] = {1'b1, 32'h1234_5678, 32'h0EDC_BA98, 1'b0, 32'h2111_1110, 1'b0, 1'b0};

    // reset values
    do_reset();
    @(posedge clk); #1;
    check_eq("reset_state", dbg_state, 2'd0);
    check_eq("reset_rsp_valid", rsp_valid, 1'b0);
    check_eq("reset_op_count", op_count, 16'd0);
    check_eq("reset_rsp", {rsp_id, rsp_Co, rsp_ovf, rsp_add}, 35'd0);

    // directed single operations; vector 1 sees 5 cycles of backpressure
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin);
      exp_q.push_back({vecs[i].id, vecs[i].co, vecs[i].ovf, vecs[i].add});
      expect_rsp((i == 1) ? 5 : 0);
    end

    // contention: both valid continuously after reset -> 0,1,0,1
    do_reset();
    @(negedge clk);
    r0_inA = 32'd100; r0_inB = 32'd1; r0_Cin = 1'b0;
    r1_inA = 32'd200; r1_inB = 32'd2; r1_Cin = 1'b1;
    rsp_ready = 1'b1;
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int t;
      t = 0;
      do begin
        @(posedge clk); #1;
        t++;
      end while (!rsp_valid && t < 12);
      if (k == 3) begin
        r0_valid = 1'b0;
        r1_valid = 1'b0;
      end
      check_eq("rr_seen", rsp_valid, 1'b1);
      check_eq("rr_id", rsp_id, (k % 2 == 1));
      check_eq("rr_add", rsp_add, (k % 2 == 1) ? 32'd203 : 32'd101);
    end
    @(posedge clk); #1;
    check_eq("rr_op_count", op_count, 16'd4);

    // reset mid-EXEC abandons the operation and restores tie priority to r0
    do_reset();
    issue(1'b0, 32'd9, 32'd9, 1'b0);
    @(posedge clk); #1;
    check_eq("in_exec", dbg_state, 2'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_idle", dbg_state, 2'd0);
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        if (rsp_valid) seen = 1'b1;
      end
      check_eq("abort_no_rsp", seen, 1'b0);
    end
    check_eq("abort_op_count", op_count, 16'd0);
    @(negedge clk);
    r0_inA = 32'd3; r0_inB = 32'd4; r0_Cin = 1'b0;
    r1_inA = 32'd5; r1_inB = 32'd6; r1_Cin = 1'b0;
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    #1;
    check_eq("abort_tie_r0", {r0_ready, r1_ready}, 2'b10);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 32'd7});
    expect_rsp(0);

    // counter wrap: preload 0xFFFF completions
    @(negedge clk);
    force dut.op_count = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.op_count;
    #1;
    check_eq("preload", op_count, 16'hFFFF);
    exp_count = 16'hFFFF;
    issue(1'b1, 32'd1, 32'd1, 1'b0);
    exp_q.push_back({1'b1, 1'b0, 1'b0, 32'd2});
    expect_rsp(0);
    check_eq("wrap_zero", op_count, 16'h0000);

    check_eq("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
